slave_port: RTL and testbench
=============================

# slave_port

Serial bus slave interface, the downstream counterpart of `master_port`. It deserialises the 16-bit address and the 8-bit write data that a granted master shifts over `wr_bus`, and issues single-cycle write or read requests to a local memory. On reads it serialises the returned byte onto `rd_bus`, asserting `split` while the memory is slow when splitting is enabled. It sits between the bus mux/decoder and one slave memory.

## Interface
- `ADDR_WIDTH`, default 12: local memory address width. The low `ADDR_WIDTH` bits of the received 16-bit address drive `s_addr`.
- `SPLIT_EN`, default 1: 1 means assert `split` while waiting for read data; 0 means hold `split` low.
- `clk` in 1: bus clock.
- `rstn` in 1: asynchronous, active-low reset.
- `sel` in 1: decoder select. High while this slave is the addressed target.
- `mode` in 1: transfer direction from the master. 1 is write, 0 is read.
- `wr_bus` in 1: serial address/write-data bit, MSB first.
- `master_valid` in 1: master is driving a valid bit on `wr_bus`.
- `slave_ready` out 1: slave accepts a `wr_bus` bit this cycle.
- `master_ready` in 1: master is sampling `rd_bus` this cycle.
- `slave_valid` out 1: `rd_bus` carries a valid bit.
- `rd_bus` out 1: serial read data, MSB first.
- `split` out 1: slave requests bus release pending read data.
- `s_addr` out ADDR_WIDTH: memory address, held from the end of the address phase until the next transfer.
- `s_wr_data` out 8: memory write data.
- `s_wr_en` out 1: one-cycle memory write strobe.
- `s_rd_en` out 1: one-cycle memory read strobe.
- `s_rd_data` in 8: memory read data, valid with `s_rd_valid`.
- `s_rd_valid` in 1: read data return. Arrives 1 or more cycles after `s_rd_en`.

## Operation
- **Bit accept.** A bit is accepted on a rising edge where `sel & master_valid & slave_ready` is true. A 5-bit counter `bit_cnt` tracks accepted bits.
- **State machine.** States are IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA. `slave_ready` is high only in IDLE, ADDR and WDATA.
- **IDLE.**
  - On a bit accept: shift the bit into `addr_sr[15:0]`, latch `mode`, set `bit_cnt`=1, go to ADDR.
- **ADDR.**
  - Each accept shifts `addr_sr` left with `wr_bus` into the LSB, then `bit_cnt`++.
  - On the 16th accept: load `s_addr` = `addr_sr[ADDR_WIDTH-1:0]` including the final bit, clear `bit_cnt`.
  - Then go to WDATA if the latched mode is 1, else to RREQ.
- **WDATA.**
  - Shift bits into `wdata_sr`. On the 8th accept, load `s_wr_data` and go to WRITE.
- **WRITE.**
  - `s_wr_en`=1 for exactly one cycle, then go to IDLE.
- **RREQ.**
  - `s_rd_en`=1 for exactly one cycle, then go to RWAIT.
- **RWAIT.**
  - `split` = SPLIT_EN.
  - On `s_rd_valid`: load `rdata_sr` from `s_rd_data`, clear `bit_cnt`, go to RDATA. `split` drops the same cycle the state leaves RWAIT.
- **RDATA.**
  - `slave_valid`=1 and `rd_bus`=`rdata_sr[7]`.
  - On `master_ready & slave_valid`: shift `rdata_sr` left, `bit_cnt`++.
  - After the 8th shift, go to IDLE.
- **Abort rules.**
  - In ADDR or WDATA, if `sel`=0 or `master_valid`=0: go to IDLE and clear `bit_cnt`. No memory strobe is issued. This covers a decoder NACK and a master timeout/restart.
  - `sel` is ignored in RREQ, RWAIT and RDATA. A read in progress always completes.
- **Busy.** While the slave is in WRITE, RREQ, RWAIT or RDATA, `slave_ready`=0. A second master addressing this slave during a split stalls and times out on its own.
- **Write data path.** `s_wr_data` holds its value until the next write.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. `s_addr`, `s_wr_data`, the shift registers and `bit_cnt` are all 0.
- **Reset mid-transfer.** Asserting `rstn` low at any point returns immediately to the reset values. A pending `s_rd_valid` after reset is ignored.
- **Write latency.** `s_wr_en` is high in the cycle after the edge that accepts data bit 8.
- **Read request latency.** `s_rd_en` is high in the cycle after the edge that accepts address bit 16.
- **Read return latency.** `slave_valid` rises in the cycle after the edge on which `s_rd_valid` is sampled.
- **Back-to-back transfers.** After WRITE, or after the last RDATA bit, IDLE may accept a new first address bit on the very next edge.
- **Read backpressure.** `master_ready` low in RDATA holds `rd_bus` and `bit_cnt`.
- **Abort priority.** Abort has priority over bit accept when both conditions occur in the same cycle.

## Test plan
- **Write.** Shift address 0x0A5C then data 0xB7 with `mode`=1 and `master_valid` continuous. Expect `s_wr_en` for one cycle with `s_addr`=0xA5C and `s_wr_data`=0xB7. `slave_ready` is low in WRITE only.
- **Read, no split.** Shift address 0x0123 with `mode`=0. Expect `s_rd_en` one cycle after bit 16. Return `s_rd_data`=0x5A two cycles later. Expect `rd_bus` to produce 0,1,0,1,1,0,1,0 with `slave_valid`, then IDLE.
- **Split.** With SPLIT_EN=1, hold `s_rd_valid` off for 20 cycles. Expect `split` high for the whole of RWAIT and low the cycle after `s_rd_valid`. `slave_valid` must be 0 throughout RWAIT. With SPLIT_EN=0, `split` stays 0.
- **Abort.** Drop `sel` after 6 address bits. Expect return to IDLE with no strobes. A fresh write to 0x0001/0x3C then succeeds with the correct address.
- **Backpressure and reset.** During RDATA, toggle `master_ready` low for 3 cycles: the `rd_bus` bit must hold. Pull `rstn` low mid-RDATA: all outputs must be 0 immediately.
- **Busy.** While in RWAIT, assert `sel` and `master_valid` from another master. Expect `slave_ready`=0 and no change to `s_addr`.

Source files
------------

// File: rtl/slave_port.sv
// Serial bus slave: deserialises address/write data from wr_bus, issues single-cycle
// memory write/read strobes, and serialises returned read data onto rd_bus.
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sel,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  input  logic                  master_ready,
  output logic                  slave_valid,
  output logic                  rd_bus,
  output logic                  split,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [7:0]            s_wr_data,
  output logic                  s_wr_en,
  output logic                  s_rd_en,
  input  logic [7:0]            s_rd_data,
  input  logic                  s_rd_valid
);

  // Handshakes: a wr_bus bit moves on an edge where sel & master_valid & slave_ready;
  // an rd_bus bit moves on an edge where master_ready & slave_valid.
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA} state_t;

  state_t      state;
  logic [15:0] addr_sr;
  logic [7:0]  wdata_sr;
  logic [7:0]  rdata_sr;
  logic [4:0]  bit_cnt;
  logic        mode_q;
  logic        accept;
  logic        drop;
  logic        unused_msbs;

  assign accept = sel & master_valid & slave_ready;
  assign drop   = ~sel | ~master_valid;
  assign rd_bus = rdata_sr[7];

  // Upper shift-register bits age out before they are ever loaded anywhere.
  assign unused_msbs = ^{addr_sr[15:ADDR_WIDTH-1], wdata_sr[7]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      addr_sr     <= '0;
      wdata_sr    <= '0;
      rdata_sr    <= '0;
      bit_cnt     <= '0;
      mode_q      <= 1'b0;
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      split       <= 1'b0;
      s_addr      <= '0;
      s_wr_data   <= '0;
      s_wr_en     <= 1'b0;
      s_rd_en     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          slave_ready <= 1'b1;
          if (accept) begin
            addr_sr <= {addr_sr[14:0], wr_bus};
            mode_q  <= mode;
            bit_cnt <= 5'd1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          // Abort wins: losing sel or master_valid mid-phase drops the transfer silently.
          if (drop) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            addr_sr <= {addr_sr[14:0], wr_bus};
            if (bit_cnt == 5'd15) begin
              s_addr  <= {addr_sr[ADDR_WIDTH-2:0], wr_bus};
              bit_cnt <= '0;
              if (mode_q) begin
                state <= WDATA;
              end else begin
                slave_ready <= 1'b0;
                s_rd_en     <= 1'b1;
                state       <= RREQ;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WDATA: begin
          if (drop) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            wdata_sr <= {wdata_sr[6:0], wr_bus};
            if (bit_cnt == 5'd7) begin
              s_wr_data   <= {wdata_sr[6:0], wr_bus};
              bit_cnt     <= '0;
              slave_ready <= 1'b0;
              s_wr_en     <= 1'b1;
              state       <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WRITE: begin
          s_wr_en     <= 1'b0;
          slave_ready <= 1'b1;
          state       <= IDLE;
        end
        RREQ: begin
          s_rd_en <= 1'b0;
          split   <= SPLIT_EN;
          state   <= RWAIT;
        end
        RWAIT: begin
          if (s_rd_valid) begin
            rdata_sr    <= s_rd_data;
            bit_cnt     <= '0;
            split       <= 1'b0;
            slave_valid <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          // Zeros shift in behind the data so rd_bus returns low once the byte is out.
          if (master_ready) begin
            rdata_sr <= {rdata_sr[6:0], 1'b0};
            if (bit_cnt == 5'd7) begin
              bit_cnt     <= '0;
              slave_valid <= 1'b0;
              slave_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: transaction-level driver tasks with a bit-queue scoreboard for reads,
// run on a split-enabled instance and a split-disabled twin sharing the same inputs.
module tb_slave_port;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          sel = 1'b0;
  logic          mode = 1'b0;
  logic          wr_bus = 1'b0;
  logic          master_valid = 1'b0;
  logic          master_ready = 1'b0;
  logic          s_rd_valid = 1'b0;
  logic [7:0]    s_rd_data = 8'h00;

  logic          slave_ready, slave_valid, rd_bus, split, s_wr_en, s_rd_en;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_wr_data;

  logic          slave_ready_n, slave_valid_n, rd_bus_n, split_n, s_wr_en_n, s_rd_en_n;
  logic [AW-1:0] s_addr_n;
  logic [7:0]    s_wr_data_n;

  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_wdata = '0;
  logic [0:0]    exp_q[$];

  slave_port #(.ADDR_WIDTH(AW), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .rd_bus(rd_bus), .split(split), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  slave_port #(.ADDR_WIDTH(AW), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rstn(rstn), .sel(sel), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready_n), .master_ready(master_ready),
    .slave_valid(slave_valid_n), .rd_bus(rd_bus_n), .split(split_n), .s_addr(s_addr_n),
    .s_wr_data(s_wr_data_n), .s_wr_en(s_wr_en_n), .s_rd_en(s_rd_en_n),
    .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, 32'(slave_ready), 0);
    check({tag, "_vld"}, 32'(slave_valid), 0);
    check({tag, "_rdbus"}, 32'(rd_bus), 0);
    check({tag, "_split"}, 32'(split), 0);
    check({tag, "_addr"}, 32'(s_addr), 0);
    check({tag, "_wdata"}, 32'(s_wr_data), 0);
    check({tag, "_strobes"}, 32'({s_wr_en, s_rd_en}), 0);
    check({tag, "_twin"}, 32'({slave_ready_n, slave_valid_n, rd_bus_n, split_n,
                               s_wr_en_n, s_rd_en_n, s_addr_n, s_wr_data_n}), 0);
  endtask

  // Shifts the top n bits of v, MSB first, one bit per cycle.
  task automatic shift_bits(input logic [23:0] v, input int n, input logic m);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("shift_ready", 32'(slave_ready), 1);
      check("shift_no_strobe", 32'({s_wr_en, s_rd_en}), 0);
      sel = 1'b1; master_valid = 1'b1; mode = m; wr_bus = v[23-i];
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    shift_bits({a, d}, 24, 1'b1);
    @(negedge clk);
    sel = 1'b0; master_valid = 1'b0;
    last_addr = a[AW-1:0];
    last_wdata = d;
    check("wr_en", 32'(s_wr_en), 1);
    check("wr_no_rd_en", 32'(s_rd_en), 0);
    check("wr_ready_low", 32'(slave_ready), 0);
    check("wr_addr", 32'(s_addr), 32'(last_addr));
    check("wr_data", 32'(s_wr_data), 32'(last_wdata));
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int delay,
                         input logic busy, input logic bp3);
    int   cyc;
    logic mr;
    shift_bits({a, 8'h00}, 16, 1'b0);
    @(negedge clk);
    sel = 1'b0; master_valid = 1'b0;
    last_addr = a[AW-1:0];
    check("rd_en", 32'(s_rd_en), 1);
    check("rd_no_wr_en", 32'(s_wr_en), 0);
    check("rreq_ready_low", 32'(slave_ready), 0);
    check("rreq_split_low", 32'(split), 0);
    check("rd_addr", 32'(s_addr), 32'(last_addr));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check("rwait_rd_en_low", 32'(s_rd_en), 0);
      check("rwait_split", 32'(split), 1);
      check("rwait_split_off", 32'(split_n), 0);
      check("rwait_valid_low", 32'(slave_valid), 0);
      check("rwait_ready_low", 32'(slave_ready), 0);
      if (busy) begin
        sel = 1'b1; master_valid = 1'b1;
        mode = 1'($urandom_range(0, 1)); wr_bus = 1'($urandom_range(0, 1));
      end
      if (k == delay - 1) begin
        s_rd_valid = 1'b1; s_rd_data = d;
      end
    end
    @(negedge clk);
    s_rd_valid = 1'b0; s_rd_data = 8'($urandom); sel = 1'b0; master_valid = 1'b0;
    check("rdata_split_low", 32'(split), 0);
    check("rdata_addr_held", 32'(s_addr), 32'(last_addr));
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      check("rdata_valid", 32'(slave_valid), 1);
      check("rdata_bit", 32'(rd_bus), 32'(exp_q[0]));
      check("rdata_ready_low", 32'(slave_ready), 0);
      if (bp3 && cyc >= 2 && cyc < 5) mr = 1'b0;
      else mr = ($urandom_range(0, 3) != 0);
      master_ready = mr;
      if (mr) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    master_ready = 1'b0;
    check("rdata_budget", exp_q.size(), 0);
    exp_q.delete();
    check("rdata_end_valid", 32'(slave_valid), 0);
    check("rdata_end_ready", 32'(slave_ready), 1);
  endtask

  task automatic abort_xfer(input logic [23:0] v, input int n, input logic m, input logic drop_sel);
    logic [15:0] a;
    a = v[23:8];
    shift_bits(v, n, m);
    @(negedge clk);
    if (drop_sel) sel = 1'b0;
    else master_valid = 1'b0;
    wr_bus = 1'($urandom_range(0, 1));
    if (n >= 16) last_addr = a[AW-1:0];
    @(negedge clk);
    sel = 1'b0; master_valid = 1'b0;
    check("abort_ready", 32'(slave_ready), 1);
    check("abort_no_strobe", 32'({s_wr_en, s_rd_en}), 0);
    check("abort_addr", 32'(s_addr), 32'(last_addr));
    check("abort_wdata", 32'(s_wr_data), 32'(last_wdata));
    @(negedge clk);
    check("abort_no_strobe2", 32'({s_wr_en, s_rd_en}), 0);
  endtask

  task automatic reset_mid_read(input logic [15:0] a, input logic [7:0] d);
    shift_bits({a, 8'h00}, 16, 1'b0);
    @(negedge clk);
    sel = 1'b0; master_valid = 1'b0;
    @(negedge clk);
    s_rd_valid = 1'b1; s_rd_data = d;
    @(negedge clk);
    s_rd_valid = 1'b0; master_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", 32'(slave_valid), 1);
    rstn = 1'b0; s_rd_valid = 1'b1; s_rd_data = 8'hFF;
    #1;
    check_reset("mid_reset");
    master_ready = 1'b0;
    last_addr = '0; last_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 32'(slave_valid), 0);
    check("post_reset_split", 32'(split), 0);
    check("post_reset_ready", 32'(slave_ready), 1);
    check("post_reset_no_strobe", 32'({s_wr_en, s_rd_en}), 0);
    s_rd_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, n;
    logic [15:0] a;
    logic [7:0]  d;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    do_write(16'h0A5C, 8'hB7);
    do_read(16'h0123, 8'h5A, 2, 1'b0, 1'b0);
    do_read(16'h0456, 8'hC3, 20, 1'b1, 1'b0);
    abort_xfer({16'h0F0F, 8'h00}, 6, 1'b1, 1'b1);
    do_write(16'h0001, 8'h3C);
    abort_xfer({16'h0777, 8'hAA}, 19, 1'b1, 1'b0);
    do_read(16'h0FFF, 8'h96, 1, 1'b0, 1'b1);
    do_write(16'hF800, 8'h01);
    do_write(16'h07FF, 8'hFE);
    reset_mid_read(16'h0321, 8'hE1);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        do_write(a, d);
      end else if (kind == 1) begin
        do_read(a, d, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        n = $urandom_range(0, 1) ? $urandom_range(1, 15) : $urandom_range(16, 23);
        abort_xfer({a, d}, n, (n >= 16) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
